// File: rtl/i2c_pkg.sv
// Shared types and constants for the write-only I2C master.
package i2c_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_START,
    ST_ADDR,
    ST_WORD,
    ST_DATA,
    ST_ACK,
    ST_STOP
  } state_t;

  typedef enum logic [1:0] {Q0, Q1, Q2, Q3} phase_t;

  localparam logic       I2C_WRITE = 1'b0;
  localparam logic [2:0] MAX_LEN   = 3'd4;

  function automatic logic [2:0] clamp_len(input logic [2:0] l);
    return (l > MAX_LEN) ? MAX_LEN : l;
  endfunction

endpackage

// File: rtl/i2c_qtr_tick.sv
// Quarter-bit strobe: pulses once every QTR clocks while enabled.
module i2c_qtr_tick #(
  parameter int QTR = 250
) (
  input  logic clk,
  input  logic reset,
  input  logic en,
  input  logic clear,
  output logic tick
);

  localparam int             CW   = (QTR > 1) ? $clog2(QTR) : 1;
  localparam logic [CW-1:0]  LAST = CW'(QTR - 1);

  logic [CW-1:0] cnt_reg;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt_reg <= '0;
    end else if (clear || !en || (cnt_reg == LAST)) begin
      cnt_reg <= '0;
    end else begin
      cnt_reg <= cnt_reg + 1'b1;
    end
  end

  assign tick = en && !clear && (cnt_reg == LAST);

endmodule

// File: rtl/i2c_master_wr.sv
// Write-only I2C master: START, address, register index, 0..4 data bytes, STOP.
module i2c_master_wr
  import i2c_pkg::*;
#(
  parameter int CLK_HZ = 100_000_000,
  parameter int SCL_HZ = 100_000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       start,
  input  logic [6:0] slv_addr,
  input  logic [7:0] word_addr,
  input  logic [2:0] len,
  input  logic [7:0] tx_data,
  input  logic       tx_valid,
  output logic       tx_ready,
  output logic       scl,
  inout  wire        sda,
  output logic       busy,
  output logic       done,
  output logic       nack
);

  localparam int QTR = CLK_HZ / (4 * SCL_HZ);

  // Reset asserts immediately but releases only after two clean clock edges.
  logic [1:0] rst_sync_reg;
  logic       rst_n;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) rst_sync_reg <= 2'b00;
    else        rst_sync_reg <= {rst_sync_reg[0], 1'b1};
  end
  assign rst_n = rst_sync_reg[1];

  state_t     state_reg, after_ack_reg;
  phase_t     phase_reg;
  logic [2:0] bit_cnt_reg, byte_cnt_reg, len_reg;
  logic [7:0] shreg, word_reg;
  logic       ack_bit_reg, nack_flag_reg, fetch_reg, lead_reg;
  logic       scl_reg, sda_oe_reg, busy_reg, done_reg, nack_reg, tx_ready_reg;
  logic       tick, tick_clear;

  // Restart the quarter timer when a data byte is loaded so its first Q0 is a full quarter away.
  assign tick_clear = (state_reg == ST_DATA) && fetch_reg && tx_valid;

  i2c_qtr_tick #(.QTR(QTR)) u_tick (
    .clk   (clk),
    .reset (rst_n),
    .en    (busy_reg),
    .clear (tick_clear),
    .tick  (tick)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg     <= ST_IDLE;
      after_ack_reg <= ST_IDLE;
      phase_reg     <= Q0;
      bit_cnt_reg   <= '0;
      byte_cnt_reg  <= '0;
      len_reg       <= '0;
      shreg         <= '0;
      word_reg      <= '0;
      ack_bit_reg   <= 1'b0;
      nack_flag_reg <= 1'b0;
      fetch_reg     <= 1'b0;
      lead_reg      <= 1'b0;
      scl_reg       <= 1'b1;
      sda_oe_reg    <= 1'b0;
      busy_reg      <= 1'b0;
      done_reg      <= 1'b0;
      nack_reg      <= 1'b0;
      tx_ready_reg  <= 1'b0;
    end else begin
      done_reg     <= 1'b0;
      tx_ready_reg <= 1'b0;
      case (state_reg)
        ST_IDLE: begin
          if (start) begin
            len_reg       <= clamp_len(len);
            word_reg      <= word_addr;
            shreg         <= {slv_addr, I2C_WRITE};
            bit_cnt_reg   <= '0;
            byte_cnt_reg  <= '0;
            nack_flag_reg <= 1'b0;
            phase_reg     <= Q0;
            busy_reg      <= 1'b1;
            state_reg     <= ST_START;
          end
        end
        ST_START: begin
          if (tick) begin
            case (phase_reg)
              Q0:      begin sda_oe_reg <= 1'b1; phase_reg <= Q1; end
              Q1:      phase_reg <= Q2;
              default: begin
                scl_reg    <= 1'b0;
                sda_oe_reg <= ~shreg[7];
                phase_reg  <= Q0;
                state_reg  <= ST_ADDR;
              end
            endcase
          end
        end
        ST_ADDR, ST_WORD, ST_DATA: begin
          if (fetch_reg) begin
            if (tx_valid) begin
              tx_ready_reg <= 1'b1;
              shreg        <= tx_data;
              byte_cnt_reg <= byte_cnt_reg + 3'd1;
              fetch_reg    <= 1'b0;
              lead_reg     <= 1'b1;
            end
          end else if (tick) begin
            if (lead_reg) begin
              lead_reg   <= 1'b0;
              sda_oe_reg <= ~shreg[7];
              phase_reg  <= Q0;
            end else begin
              case (phase_reg)
                Q0:      phase_reg <= Q1;
                Q1:      begin scl_reg <= 1'b1; phase_reg <= Q2; end
                Q2:      phase_reg <= Q3;
                default: begin
                  scl_reg     <= 1'b0;
                  phase_reg   <= Q0;
                  bit_cnt_reg <= bit_cnt_reg + 3'd1;
                  if (bit_cnt_reg == 3'd7) begin
                    sda_oe_reg    <= 1'b0;
                    after_ack_reg <= state_reg;
                    state_reg     <= ST_ACK;
                  end else begin
                    shreg      <= {shreg[6:0], 1'b0};
                    sda_oe_reg <= ~shreg[6];
                  end
                end
              endcase
            end
          end
        end
        ST_ACK: begin
          if (tick) begin
            case (phase_reg)
              Q0:      phase_reg <= Q1;
              Q1:      begin scl_reg <= 1'b1; phase_reg <= Q2; end
              Q2:      begin ack_bit_reg <= sda; phase_reg <= Q3; end
              default: begin
                scl_reg   <= 1'b0;
                phase_reg <= Q0;
                if (ack_bit_reg) begin
                  nack_flag_reg <= 1'b1;
                  sda_oe_reg    <= 1'b1;
                  state_reg     <= ST_STOP;
                end else if (after_ack_reg == ST_ADDR) begin
                  shreg      <= word_reg;
                  sda_oe_reg <= ~word_reg[7];
                  state_reg  <= ST_WORD;
                end else if (byte_cnt_reg != len_reg) begin
                  fetch_reg <= 1'b1;
                  state_reg <= ST_DATA;
                end else begin
                  sda_oe_reg <= 1'b1;
                  state_reg  <= ST_STOP;
                end
              end
            endcase
          end
        end
        ST_STOP: begin
          if (tick) begin
            case (phase_reg)
              Q0:      phase_reg <= Q1;
              Q1:      begin scl_reg <= 1'b1; phase_reg <= Q2; end
              Q2:      begin sda_oe_reg <= 1'b0; phase_reg <= Q3; end
              default: begin
                // bit_cnt is idle here and marks the extra bus-free quarter.
                if (bit_cnt_reg == 3'd0) begin
                  bit_cnt_reg <= 3'd1;
                end else begin
                  bit_cnt_reg  <= '0;
                  byte_cnt_reg <= '0;
                  busy_reg     <= 1'b0;
                  done_reg     <= 1'b1;
                  nack_reg     <= nack_flag_reg;
                  state_reg    <= ST_IDLE;
                end
              end
            endcase
          end
        end
        default: state_reg <= ST_IDLE;
      endcase
    end
  end

  assign scl      = scl_reg;
  assign sda      = sda_oe_reg ? 1'b0 : 1'bz;
  assign busy     = busy_reg;
  assign done     = done_reg;
  assign nack     = nack_reg;
  assign tx_ready = tx_ready_reg;

endmodule

// File: doc/i2c_master_wr.md
I2C_MASTER_WR -- requirements
Module: i2c_master_wr

Interface
REQ-001 CLK_HZ, 100_000_000, system clock frequency in Hz.
REQ-002 SCL_HZ, 100_000, target SCL frequency in Hz; QTR = CLK_HZ/(4*SCL_HZ) clocks per quarter bit; QTR >= 2.
REQ-003 clk  input  1  system clock, all logic on rising edge.
REQ-004 reset  input  1  asynchronous, active-low reset.
REQ-005 start  input  1  one-cycle request; sampled only in IDLE.
REQ-006 slv_addr  input  7  target address, latched at accepted start.
REQ-007 word_addr  input  8  first register index, latched at accepted start.
REQ-008 len  input  3  data bytes to send, 0..4, latched at accepted start; values 5..7 are treated as 4.
REQ-009 tx_data  input  8  next data byte.
REQ-010 tx_valid  input  1  tx_data is valid.
REQ-011 tx_ready  output  1  one-cycle pulse when tx_data is consumed.
REQ-012 scl  output  1  push-pull serial clock.
REQ-013 sda  inout  1  open-drain data line; drives 0 or releases to Z, never drives 1.
REQ-014 busy  output  1  high from accepted start until return to IDLE.
REQ-015 done  output  1  one-cycle pulse on return to IDLE after a transaction.
REQ-016 nack  output  1  result of the last transaction: 1 = NACK received; updates at the done pulse.

Function
REQ-017 A quarter-tick pulses every QTR clocks while busy; all SCL/SDA changes occur on ticks only.
REQ-018 States: IDLE, START, ADDR, WORD, DATA, ACK, STOP.
REQ-019 IDLE: scl=1, sda released; start=1 latches the inputs and enters START on the next clock.
REQ-020 START: scl held high; SDA pulled low for 2 quarters; then scl=0 and the block enters ADDR.
REQ-021 Each bit takes 4 quarters (Q0..Q3): Q0 scl=0, SDA updated; Q1 scl=0; Q2-Q3 scl=1. SDA changes only in Q0.
REQ-022 Byte order MSB first; ADDR byte = {slv_addr, 1'b0} (write only); WORD byte = word_addr.
REQ-023 After each 8-bit byte, ACK state: SDA released for one bit; SDA sampled at the Q2->Q3 tick; 0 = ACK.
REQ-024 Sampled 1 in ACK: set the nack flag and go to STOP; no further bytes are sent.
REQ-025 Sequence after an ACK: ADDR -> WORD; WORD -> DATA if len>0, else STOP; DATA -> DATA while bytes remain, else STOP.
REQ-026 Before each DATA byte's Q0: wait with scl=0 until tx_valid=1, then pulse tx_ready for one cycle and load tx_data; a stall has no timeout.
REQ-027 STOP: Q0-Q1 scl=0, SDA low; Q2 scl=1, SDA low; Q3 SDA released; one further quarter of bus-free time; then IDLE with done=1.
REQ-028 start while busy is ignored and not queued.
REQ-029 Byte counter 3 bits; bit counter 3 bits, wraps 7->0 at the byte boundary.

Reset
REQ-030 Asserting reset (low) at any time: state=IDLE, scl=1, sda released, busy=0, done=0, nack=0, tx_ready=0, all counters 0; a transaction in flight is abandoned with no STOP issued.
REQ-031 Deassertion is synchronized to clk before the first state change.

Structure
REQ-032 Shared package i2c_pkg: state enum, bit-phase enum (Q0..Q3), and the R/W bit constant I2C_WRITE=1'b0.
REQ-033 One sub-module i2c_qtr_tick (parameter QTR, inputs en/clear, output tick); all other logic stays in the top level.

Verification
REQ-034 The bench uses CLK_HZ=4_000_000, SCL_HZ=100_000 (QTR=10) and pairs the block with the team's existing I2C slave (address 7'h00) plus a pull-up model.
REQ-035 slv_addr=0x00, word_addr=0x01, len=2, data 0xA5, 0x3C -> slave reg1=0xA5, reg2=0x3C; nack=0; exactly 2 tx_ready pulses; one done pulse.
REQ-036 slv_addr=0x2A, len=1 -> NACK on the address byte; STOP follows; nack=1; 0 tx_ready pulses; slave registers unchanged.
REQ-037 len=3 with tx_valid withheld for 500 clocks before byte 2 -> scl held low for the whole stall; transfer then completes; regs 0..2 correct.
REQ-038 start pulsed again mid-transfer -> ignored; exactly one done pulse.
REQ-039 reset asserted during the WORD byte -> scl=1 and sda=Z within the same cycle; busy=0; a following transaction with len=4 completes correctly.
